// File: rtl/ulpi_transmit_if.sv
// Link-side bundle for ulpi_transmit: encoder AXI-Stream bytes, ULPI pads,
// status and register-write request. 'master' is the link, 'slave' the environment.
interface ulpi_transmit_if;
    logic       tx_tvalid_i;
    logic       tx_tready_o;
    logic       tx_tlast_i;
    logic [7:0] tx_tdata_i;
    logic       ulpi_dir_i;
    logic       ulpi_nxt_i;
    logic       ulpi_stp_o;
    logic [7:0] ulpi_data_o;
    logic       ulpi_data_oe_o;
    logic       tx_busy_o;
    logic       tx_abort_o;
    logic       reg_wr_i;
    logic [5:0] reg_addr_i;
    logic [7:0] reg_data_i;
    logic       reg_done_o;

    modport master (
        input  tx_tvalid_i, tx_tlast_i, tx_tdata_i,
        input  ulpi_dir_i, ulpi_nxt_i,
        input  reg_wr_i, reg_addr_i, reg_data_i,
        output tx_tready_o, ulpi_stp_o, ulpi_data_o, ulpi_data_oe_o,
        output tx_busy_o, tx_abort_o, reg_done_o
    );

    modport slave (
        output tx_tvalid_i, tx_tlast_i, tx_tdata_i,
        output ulpi_dir_i, ulpi_nxt_i,
        output reg_wr_i, reg_addr_i, reg_data_i,
        input  tx_tready_o, ulpi_stp_o, ulpi_data_o, ulpi_data_oe_o,
        input  tx_busy_o, tx_abort_o, reg_done_o
    );
endinterface

// File: rtl/ulpi_transmit.sv
// ULPI link transmitter: turns encoder packets into TX CMD + nxt-paced bytes + stp.
// Define ULPI_REGWR_EN to add ULPI register writes (RCMD/RDATA/RSTOP states).
//
// state | meaning
// IDLE  | bus free, waiting for a PID byte (or register write request)
// TXCMD | TX CMD driven, waiting for nxt
// DATA  | payload bytes, one per nxt
// STOP  | stp with 8'h00 for one cycle
// DRAIN | discard encoder bytes through tlast after an abort
// RCMD  | register write command {2'b10, addr} driven
// RDATA | register value driven
// RSTOP | stp for the register write, reg_done pulse
module ulpi_transmit (
    input  logic          clock,
    input  logic          reset,
    ulpi_transmit_if.master bus
);

`ifdef ULPI_REGWR_EN
    typedef enum logic [2:0] {
        IDLE, TXCMD, DATA, STOP, DRAIN, RCMD, RDATA, RSTOP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, TXCMD, DATA, STOP, DRAIN
    } state_t;
`endif

    state_t     state_q, state_d;
    logic       dir_q;
    logic [7:0] data_q, data_d;
    logic       stp_q, stp_d;
    logic       abort_q, abort_d;
    logic       done_q, done_d;
    logic       last_q, last_d;
    logic       tready;
    logic       link_ok;
    logic       pid_bad;

    // Link may drive only after a full turnaround: dir low now and last cycle.
    assign link_ok = !bus.ulpi_dir_i && !dir_q;
    assign pid_bad = bus.tx_tdata_i[7:4] != ~bus.tx_tdata_i[3:0];

`ifndef ULPI_REGWR_EN
    logic reg_unused;
    assign reg_unused = ^{bus.reg_wr_i, bus.reg_addr_i, bus.reg_data_i};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            dir_q   <= 1'b1;
            data_q  <= 8'h00;
            stp_q   <= 1'b0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= bus.ulpi_dir_i;
            data_q  <= data_d;
            stp_q   <= stp_d;
            abort_q <= abort_d;
            done_q  <= done_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        stp_d   = 1'b0;
        abort_d = 1'b0;
        done_d  = 1'b0;
        last_d  = last_q;
        tready  = 1'b0;
        case (state_q)
            IDLE: begin
                data_d = 8'h00;
                tready = link_ok;
                if (link_ok && bus.tx_tvalid_i) begin
                    // A malformed PID is still sent as-is; the abort flags it upstream.
                    data_d  = {4'b0100, bus.tx_tdata_i[3:0]};
                    last_d  = bus.tx_tlast_i;
                    abort_d = pid_bad;
                    state_d = TXCMD;
                end
`ifdef ULPI_REGWR_EN
                else if (link_ok && bus.reg_wr_i) begin
                    data_d  = {2'b10, bus.reg_addr_i};
                    state_d = RCMD;
                end
`endif
            end
            TXCMD, DATA: begin
                tready = bus.ulpi_nxt_i && link_ok && !last_q;
                if (state_q == DATA && bus.ulpi_dir_i) begin
                    // PHY took the bus mid-packet: no stp, flush what remains.
                    abort_d = 1'b1;
                    data_d  = 8'h00;
                    state_d = last_q ? IDLE : DRAIN;
                end else if (bus.ulpi_nxt_i && link_ok) begin
                    if (last_q) begin
                        stp_d   = 1'b1;
                        data_d  = 8'h00;
                        state_d = STOP;
                    end else if (bus.tx_tvalid_i) begin
                        data_d  = bus.tx_tdata_i;
                        last_d  = bus.tx_tlast_i;
                        state_d = DATA;
                    end else begin
                        // Underrun: stp with all-ones forces a bit-stuff error on the wire.
                        stp_d   = 1'b1;
                        data_d  = 8'hFF;
                        abort_d = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            STOP: begin
                data_d  = 8'h00;
                state_d = IDLE;
            end
            DRAIN: begin
                tready = 1'b1;
                data_d = 8'h00;
                if (bus.tx_tvalid_i && bus.tx_tlast_i) state_d = IDLE;
            end
`ifdef ULPI_REGWR_EN
            RCMD: begin
                if (bus.ulpi_nxt_i && link_ok) begin
                    data_d  = bus.reg_data_i;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                if (!link_ok) begin
                    data_d  = {2'b10, bus.reg_addr_i};
                    state_d = RCMD;
                end else if (bus.ulpi_nxt_i) begin
                    stp_d   = 1'b1;
                    data_d  = 8'h00;
                    done_d  = 1'b1;
                    state_d = RSTOP;
                end
            end
            RSTOP: begin
                data_d  = 8'h00;
                state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign bus.tx_tready_o    = tready;
    assign bus.ulpi_stp_o     = stp_q;
    assign bus.ulpi_data_o    = data_q;
    assign bus.ulpi_data_oe_o = link_ok;
    assign bus.tx_busy_o      = state_q != IDLE;
    assign bus.tx_abort_o     = abort_q;
    assign bus.reg_done_o     = done_q;

endmodule
